// File: rtl/led_ctrl_pkg.sv
// Shared register map, mode encodings and control bit positions for the
// Wishbone LED controller.
package led_ctrl_pkg;

    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_PRESCALE  = 1;
    localparam int ADDR_BLINK     = 2;
    localparam int ADDR_STATUS    = 3;
    localparam int ADDR_CHAN_BASE = 4;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_INV_BIT     = 1;
    localparam int STATUS_PHASE_BIT = 15;
    localparam int MODE_LSB         = 8;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } led_mode_e;

    function automatic logic mode_uses_pwm(input led_mode_e m);
        return (m == MODE_PWM) || (m == MODE_BLINK);
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: bus-visible DUTY/MODE, the shadow duty used by the
// comparator, and the raw (pre-enable, pre-invert) drive.
module led_pwm_channel
    import led_ctrl_pkg::*;
#(
    parameter int PWM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [PWM_WIDTH-1:0] wr_duty,
    input  led_mode_e            wr_mode,
    input  logic [PWM_WIDTH-1:0] pwm_cnt,
    input  logic                 pwm_wrap,
    input  logic                 blink_phase,
    output logic [PWM_WIDTH-1:0] duty,
    output led_mode_e            mode,
    output logic                 raw
);

    logic [PWM_WIDTH-1:0] active_duty;
    logic                 mode_start;
    logic                 pwm_on;

    // Entering a PWM mode from a static one loads the shadow at once so the
    // first period is not spent on a stale duty.
    assign mode_start = we && !mode_uses_pwm(mode) && mode_uses_pwm(wr_mode);

    always_ff @(posedge clk) begin
        if (!reset) begin
            duty        <= '0;
            mode        <= MODE_OFF;
            active_duty <= '0;
        end else begin
            if (we) begin
                duty <= wr_duty;
                mode <= wr_mode;
            end
            if (mode_start) begin
                active_duty <= wr_duty;
            end else if (pwm_wrap) begin
                active_duty <= duty;
            end
        end
    end

    assign pwm_on = (pwm_cnt < active_duty);

    always_comb begin
        raw = 1'b0;
        case (mode)
            MODE_OFF:   raw = 1'b0;
            MODE_ON:    raw = 1'b1;
            MODE_PWM:   raw = pwm_on;
            MODE_BLINK: raw = pwm_on && blink_phase;
            default:    raw = 1'b0;
        endcase
    end

endmodule

// File: rtl/led_ctrl_wb.sv
// Wishbone-slave LED controller: bus decode, global registers, prescaler,
// PWM counter and blink timer feeding NUM_LEDS channel instances.
module led_ctrl_wb
    import led_ctrl_pkg::*;
#(
    parameter int NUM_LEDS   = 4,
    parameter int PWM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [NUM_LEDS-1:0]   led,
    input  logic [ADDR_WIDTH-1:0] wbs_address,
    input  logic [DATA_WIDTH-1:0] wbs_writedata,
    output logic [DATA_WIDTH-1:0] wbs_readdata,
    input  logic                  wbs_write,
    input  logic                  wbs_cycle,
    output logic                  wbs_ack
);

    logic                  take;
    logic                  wr_en;
    logic                  wr_ctrl;
    logic                  wr_presc;
    logic                  wr_blink;

    logic                  ctrl_en;
    logic                  ctrl_inv;
    logic [15:0]           prescale;
    logic [15:0]           blink;

    logic [15:0]           presc_cnt;
    logic [15:0]           blink_cnt;
    logic [PWM_WIDTH-1:0]  pwm_cnt;
    logic                  blink_phase;
    logic                  tick;
    logic                  pwm_wrap;

    logic [NUM_LEDS-1:0]   raw;
    logic [NUM_LEDS-1:0]   chan_we;
    logic [PWM_WIDTH-1:0]  chan_duty [NUM_LEDS];
    led_mode_e             chan_mode [NUM_LEDS];
    logic [DATA_WIDTH-1:0] rd_mux;

    // Handshake: wbs_cycle acts as valid and !wbs_ack as ready. An access is
    // taken on an edge where both hold; writes commit on that edge and the
    // ack (with read data) follows for exactly one cycle, so a master that
    // keeps wbs_cycle high gets at most one ack every two cycles.
    assign take     = wbs_cycle && !wbs_ack;
    assign wr_en    = take && wbs_write;
    assign wr_ctrl  = wr_en && (wbs_address == ADDR_WIDTH'(ADDR_CTRL));
    assign wr_presc = wr_en && (wbs_address == ADDR_WIDTH'(ADDR_PRESCALE));
    assign wr_blink = wr_en && (wbs_address == ADDR_WIDTH'(ADDR_BLINK));

    always_ff @(posedge clk) begin
        if (!reset) begin
            wbs_ack      <= 1'b0;
            wbs_readdata <= '0;
        end else begin
            wbs_ack <= take;
            if (take) begin
                wbs_readdata <= wbs_write ? '0 : rd_mux;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_en  <= 1'b0;
            ctrl_inv <= 1'b0;
            prescale <= '0;
            blink    <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en  <= wbs_writedata[CTRL_EN_BIT];
                ctrl_inv <= wbs_writedata[CTRL_INV_BIT];
            end
            if (wr_presc) begin
                prescale <= wbs_writedata[15:0];
            end
            if (wr_blink) begin
                blink <= wbs_writedata[15:0];
            end
        end
    end

    // A PRESCALE write restarts the divider and swallows a coincident tick.
    assign tick     = (presc_cnt == prescale) && !wr_presc;
    assign pwm_wrap = tick && (pwm_cnt == '1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            if (wr_presc || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 16'd1;
            end
            if (tick) begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    // With BLINK=0 the phase is never toggled, so it stays at its set value 1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (wr_blink) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (pwm_wrap && (blink != 16'd0)) begin
            if (blink_cnt == blink - 16'd1) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        assign chan_we[g] = wr_en && (wbs_address == ADDR_WIDTH'(ADDR_CHAN_BASE + g));

        led_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .we          (chan_we[g]),
            .wr_duty     (wbs_writedata[PWM_WIDTH-1:0]),
            .wr_mode     (led_mode_e'(wbs_writedata[MODE_LSB+1:MODE_LSB])),
            .pwm_cnt     (pwm_cnt),
            .pwm_wrap    (pwm_wrap),
            .blink_phase (blink_phase),
            .duty        (chan_duty[g]),
            .mode        (chan_mode[g]),
            .raw         (raw[g])
        );
    end

    always_comb begin
        rd_mux = '0;
        case (wbs_address)
            ADDR_WIDTH'(ADDR_CTRL): begin
                rd_mux[CTRL_EN_BIT]  = ctrl_en;
                rd_mux[CTRL_INV_BIT] = ctrl_inv;
            end
            ADDR_WIDTH'(ADDR_PRESCALE): rd_mux[15:0] = prescale;
            ADDR_WIDTH'(ADDR_BLINK):    rd_mux[15:0] = blink;
            ADDR_WIDTH'(ADDR_STATUS): begin
                rd_mux[PWM_WIDTH-1:0]   = pwm_cnt;
                rd_mux[STATUS_PHASE_BIT] = blink_phase;
            end
            default: begin
                for (int i = 0; i < NUM_LEDS; i++) begin
                    if (wbs_address == ADDR_WIDTH'(ADDR_CHAN_BASE + i)) begin
                        rd_mux[PWM_WIDTH-1:0]         = chan_duty[i];
                        rd_mux[MODE_LSB+1:MODE_LSB]   = chan_mode[i];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            led <= '0;
        end else begin
            led <= {NUM_LEDS{ctrl_inv}} ^ ({NUM_LEDS{ctrl_en}} & raw);
        end
    end

endmodule

// File: tb/tb_led_ctrl_wb.sv
// Self-checking bench for led_ctrl_wb: register table, bus handshake, PWM
// duty/shadowing, blink timing, write latency and reset behaviour.
module tb_led_ctrl_wb;
    import led_ctrl_pkg::*;

    localparam int NUM_LEDS   = 4;
    localparam int PWM_WIDTH  = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int DATA_WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_LEDS-1:0]   led;
    logic [ADDR_WIDTH-1:0] wbs_address = '0;
    logic [DATA_WIDTH-1:0] wbs_writedata = '0;
    logic [DATA_WIDTH-1:0] wbs_readdata;
    logic                  wbs_write = 1'b0;
    logic                  wbs_cycle = 1'b0;
    logic                  wbs_ack;

    led_ctrl_wb #(
        .NUM_LEDS   (NUM_LEDS),
        .PWM_WIDTH  (PWM_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .led           (led),
        .wbs_address   (wbs_address),
        .wbs_writedata (wbs_writedata),
        .wbs_readdata  (wbs_readdata),
        .wbs_write     (wbs_write),
        .wbs_cycle     (wbs_cycle),
        .wbs_ack       (wbs_ack)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct {
        bit                    is_wr;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] mask;
    } vec_t;

    vec_t                  vecs[$];
    logic [DATA_WIDTH-1:0] exp_q[$];
    logic [DATA_WIDTH-1:0] mask_q[$];
    int                    n_checks = 0;
    int                    n_pass = 0;
    int                    h1, h2, z1, z2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Driver tasks: called at a falling edge, return at the falling edge
    // right after the ack cycle begins.
    task automatic bus_write(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
        @(negedge clk);
        wbs_cycle = 1'b1; wbs_write = 1'b1; wbs_address = a; wbs_writedata = d;
        @(negedge clk);
        check($sformatf("wr_ack_%0h", a), {31'd0, wbs_ack}, 32'd1);
        wbs_cycle = 1'b0; wbs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [ADDR_WIDTH-1:0] a);
        logic [DATA_WIDTH-1:0] e, m;
        @(negedge clk);
        wbs_cycle = 1'b1; wbs_write = 1'b0; wbs_address = a;
        @(negedge clk);
        check($sformatf("rd_ack_%0h", a), {31'd0, wbs_ack}, 32'd1);
        e = exp_q.pop_front();
        m = mask_q.pop_front();
        check($sformatf("rd_data_%0h", a), 32'(wbs_readdata & m), 32'(e & m));
        wbs_cycle = 1'b0;
    endtask

    task automatic read_expect(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] e,
                               input logic [DATA_WIDTH-1:0] m);
        exp_q.push_back(e);
        mask_q.push_back(m);
        bus_read(a);
    endtask

    task automatic wait_level(input int idx, input logic lvl, input string name);
        int k = 0;
        while (led[idx] !== lvl && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, led[idx]}, {31'd0, lvl});
    endtask

    // Samples led[idx] now and on the next n-1 falling edges.
    task automatic measure(input int idx, input int n, output int highs, output int max_zero);
        int run = 0;
        highs = 0; max_zero = 0;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (led[idx]) begin
                highs++; run = 0;
            end else begin
                run++;
                if (run > max_zero) max_zero = run;
            end
        end
    endtask

    initial begin
        // Register access table: reads pop expected data from the scoreboard.
        vecs.push_back(vec_t'{1'b0, 4'h0, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h1, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h2, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h3, 16'h8000, 16'h8000});
        vecs.push_back(vec_t'{1'b0, 4'h4, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h5, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h6, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h7, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'h8, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h0, 16'hFFFF, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h0, 16'h0003, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h0, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h0, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h1, 16'h1234, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h1, 16'h1234, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h1, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 4'h2, 16'hABCD, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h2, 16'hABCD, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h2, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 4'h3, 16'hFFFF, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h3, 16'h8000, 16'h8000});
        vecs.push_back(vec_t'{1'b1, 4'h4, 16'hFFFF, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h4, 16'h03FF, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h4, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 4'h7, 16'h0155, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h7, 16'h0155, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h7, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 4'h5, 16'hFC12, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h5, 16'h0012, 16'hFFFF});
        vecs.push_back(vec_t'{1'b1, 4'h5, 16'h0000, 16'h0000});
        vecs.push_back(vec_t'{1'b1, 4'h9, 16'h1234, 16'h0000});
        vecs.push_back(vec_t'{1'b0, 4'h9, 16'h0000, 16'hFFFF});
        vecs.push_back(vec_t'{1'b0, 4'hF, 16'h0000, 16'hFFFF});

        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_led", 32'(led), 32'd0);
        check("reset_ack", {31'd0, wbs_ack}, 32'd0);
        check("reset_rdata", 32'(wbs_readdata), 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) bus_write(vecs[i].addr, vecs[i].data);
            else read_expect(vecs[i].addr, vecs[i].data, vecs[i].mask);
        end
        check("led_after_table", 32'(led), 32'd0);

        // Handshake: cycle held 5 cycles -> acks on cycles 1 and 3.
        @(negedge clk);
        wbs_cycle = 1'b1; wbs_write = 1'b0; wbs_address = 4'(ADDR_CTRL);
        check("hs_cyc0", {31'd0, wbs_ack}, 32'd0);
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("hs_cyc%0d", k), {31'd0, wbs_ack}, 32'(k % 2));
        end
        wbs_cycle = 1'b0;
        repeat (2) @(negedge clk);
        check("hs_idle", {31'd0, wbs_ack}, 32'd0);

        // PWM duty 64 at prescale 0, then inverted.
        bus_write(4'(ADDR_CTRL), 16'h0001);
        bus_write(4'(ADDR_PRESCALE), 16'h0000);
        bus_write(4'(ADDR_CHAN_BASE), 16'h0240);
        repeat (300) @(negedge clk);
        measure(0, 256, h1, z1);
        check("pwm64_high", 32'(h1), 32'd64);
        bus_write(4'(ADDR_CTRL), 16'h0003);
        repeat (10) @(negedge clk);
        measure(0, 256, h1, z1);
        check("pwm64_inv_high", 32'(h1), 32'd192);
        bus_write(4'(ADDR_CTRL), 16'h0001);

        // Duty change mid-period takes effect at the next period boundary.
        bus_write(4'(ADDR_CHAN_BASE + 1), 16'h0280);
        repeat (2) @(negedge clk);
        wait_level(1, 1'b0, "ch1_fall");
        wait_level(1, 1'b1, "ch1_rise");
        fork
            begin
                measure(1, 256, h1, z1);
                @(negedge clk);
                measure(1, 256, h2, z2);
            end
            begin
                repeat (20) @(negedge clk);
                bus_write(4'(ADDR_CHAN_BASE + 1), 16'h0210);
            end
        join
        check("shadow_cur_period", 32'(h1), 32'd128);
        check("shadow_next_period", 32'(h2), 32'd16);

        // Blink: prescale 1, 2 periods per half-phase, full duty.
        bus_write(4'(ADDR_PRESCALE), 16'h0001);
        bus_write(4'(ADDR_BLINK), 16'h0002);
        bus_write(4'(ADDR_CHAN_BASE + 2), 16'h03FF);
        repeat (600) @(negedge clk);
        measure(2, 4096, h1, z1);
        check("blink_high", 32'(h1), 32'd2040);
        check("blink_off_run", 32'(z1), 32'd1026);
        read_expect(4'(ADDR_BLINK), 16'h0002, 16'hFFFF);
        bus_write(4'(ADDR_BLINK), 16'h0000);
        repeat (600) @(negedge clk);
        measure(2, 1024, h1, z1);
        check("noblink_high", 32'(h1), 32'd1020);
        check("noblink_off_run", 32'(z1), 32'd2);
        read_expect(4'(ADDR_STATUS), 16'h8000, 16'h8000);

        // Write latency of MODE=on, then a one-cycle reset pulse.
        bus_write(4'(ADDR_CHAN_BASE + 3), 16'h0100);
        check("on_latency_edge_n", {31'd0, led[3]}, 32'd0);
        @(negedge clk);
        check("on_latency_edge_n1", {31'd0, led[3]}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("pulse_led", 32'(led), 32'd0);
        check("pulse_ack", {31'd0, wbs_ack}, 32'd0);
        check("pulse_rdata", 32'(wbs_readdata), 32'd0);
        read_expect(4'(ADDR_CTRL), 16'h0000, 16'hFFFF);
        read_expect(4'(ADDR_PRESCALE), 16'h0000, 16'hFFFF);
        read_expect(4'(ADDR_BLINK), 16'h0000, 16'hFFFF);
        read_expect(4'(ADDR_STATUS), 16'h8000, 16'h8000);
        for (int i = 0; i < NUM_LEDS; i++) read_expect(4'(ADDR_CHAN_BASE + i), 16'h0000, 16'hFFFF);
        repeat (5) @(negedge clk);
        check("pulse_led_later", 32'(led), 32'd0);

        // Reset during a write: no ack, no commit.
        @(negedge clk);
        wbs_cycle = 1'b1; wbs_write = 1'b1; wbs_address = 4'(ADDR_CTRL); wbs_writedata = 16'h0003;
        reset = 1'b0;
        @(negedge clk);
        check("abort_ack", {31'd0, wbs_ack}, 32'd0);
        reset = 1'b1; wbs_cycle = 1'b0; wbs_write = 1'b0;
        @(negedge clk);
        check("abort_ack_after", {31'd0, wbs_ack}, 32'd0);
        read_expect(4'(ADDR_CTRL), 16'h0000, 16'hFFFF);
        check("abort_led", 32'(led), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
